// File: rtl/ex_stage_pipe_if.sv
// Execute-stage bundle: upstream operation, flush, downstream result and both handshakes.
interface ex_stage_pipe_if #(
  parameter int XLEN = 32,
  parameter int IRW  = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [IRW-1:0]  ir_i;
  logic [XLEN-1:0] npc_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic [XLEN-1:0] imm_i;
  logic [2:0]      alu_op;
  logic            is_branch;
  logic            use_imm;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_o;
  logic            zf_o;
  logic            of_o;
  logic            cond_o;
  logic [XLEN-1:0] b_o;
  logic [IRW-1:0]  ir_o;

  modport master (
    output in_valid, ir_i, npc_i, a_i, b_i, imm_i, alu_op, is_branch, use_imm, flush, out_ready,
    input  in_ready, out_valid, alu_o, zf_o, of_o, cond_o, b_o, ir_o
  );

  modport slave (
    input  in_valid, ir_i, npc_i, a_i, b_i, imm_i, alu_op, is_branch, use_imm, flush, out_ready,
    output in_ready, out_valid, alu_o, zf_o, of_o, cond_o, b_o, ir_o
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// Execute stage: ALU result 1 cycle after accept, MUL after MUL_LAT cycles.
// Single result register; accepts only when empty or when the held result drains this cycle.
module ex_stage_pipe #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 4,
  parameter int IRW     = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_stage_pipe_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  localparam int            CW       = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 2);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_c, out_valid_c;
  logic            accept, is_mul, mul_done;
  logic [XLEN-1:0] op_a, op_b, sum, diff, res, mul_lo;
  logic [XLEN-1:0] op_a_q, op_b_q;
  logic            res_of, slt;
  logic [XLEN-1:0] alu_q, b_q;
  logic [IRW-1:0]  ir_q;
  logic            zf_q, of_q, cond_q;

  assign is_mul   = (bus.alu_op == 3'd6);
  assign accept   = bus.in_valid && in_ready_c;
  assign mul_done = (state_q == BUSY) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = is_mul ? BUSY : FULL;
        BUSY:    if (cnt_q == '0) state_d = FULL;
        FULL: begin
          if (accept)             state_d = is_mul ? BUSY : FULL;
          else if (bus.out_ready) state_d = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      EMPTY:   in_ready_c = 1'b1;
      FULL: begin
        out_valid_c = 1'b1;
        in_ready_c  = bus.out_ready;
      end
      default: ;
    endcase
    if (rst || bus.flush) in_ready_c = 1'b0;
  end

  // Counter reaches zero in the last BUSY cycle; the result lands on the following edge.
  always_ff @(posedge clk) begin
    if (rst || bus.flush)          cnt_q <= '0;
    else if (accept && is_mul)     cnt_q <= CNT_INIT;
    else if (state_q == BUSY && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end

  assign op_a = bus.is_branch ? bus.npc_i : bus.a_i;
  assign op_b = bus.is_branch ? (bus.imm_i << 2) : (bus.use_imm ? bus.imm_i : bus.b_i);
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign slt  = $signed(op_a) < $signed(op_b);
  assign mul_lo = op_a_q * op_b_q;

  always_comb begin
    res    = '0;
    res_of = 1'b0;
    case (bus.alu_op)
      3'd0: begin
        res    = sum;
        res_of = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      end
      3'd1: begin
        res    = diff;
        res_of = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
      end
      3'd2:    res = op_a & op_b;
      3'd3:    res = op_a | op_b;
      3'd4:    res = op_a ^ op_b;
      3'd5:    res = {{(XLEN-1){1'b0}}, slt};
      default: res = '0;
    endcase
  end

  // MUL operands are parked at accept and multiplied when the countdown expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q  <= '0;
      b_q    <= '0;
      ir_q   <= '0;
      zf_q   <= 1'b0;
      of_q   <= 1'b0;
      cond_q <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (accept) begin
      alu_q  <= res;
      zf_q   <= (res == '0);
      of_q   <= res_of;
      cond_q <= (bus.a_i == '0);
      b_q    <= bus.b_i;
      ir_q   <= bus.ir_i;
      op_a_q <= op_a;
      op_b_q <= op_b;
    end else if (mul_done && !bus.flush) begin
      alu_q <= mul_lo;
      zf_q  <= (mul_lo == '0);
      of_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.alu_o     = alu_q;
  assign bus.zf_o      = zf_q;
  assign bus.of_o      = of_q;
  assign bus.cond_o    = cond_q;
  assign bus.b_o       = b_q;
  assign bus.ir_o      = ir_q;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe (XLEN=32, MUL_LAT=4, IRW=32).
module tb_ex_stage_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ex_stage_pipe_if #(.XLEN(32), .IRW(32)) bus ();

  ex_stage_pipe #(.XLEN(32), .MUL_LAT(4), .IRW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] imm, input logic [31:0] npc, input logic [31:0] ir,
                    input logic br, input logic ui);
    bus.in_valid  = v;
    bus.alu_op    = f;
    bus.a_i       = a;
    bus.b_i       = b;
    bus.imm_i     = imm;
    bus.npc_i     = npc;
    bus.ir_i      = ir;
    bus.is_branch = br;
    bus.use_imm   = ui;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic result(input string tag, input logic [31:0] alu, input logic zf, input logic of,
                        input logic cond);
    chk({tag, "_ov"},   bus.out_valid, 1);
    chk({tag, "_alu"},  bus.alu_o, alu);
    chk({tag, "_zf"},   bus.zf_o, zf);
    chk({tag, "_of"},   bus.of_o, of);
    chk({tag, "_cond"}, bus.cond_o, cond);
  endtask

  initial begin
    op(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_alu", bus.alu_o, 0);
    chk("rst_zf", bus.zf_o, 0);
    chk("rst_of", bus.of_o, 0);
    chk("rst_cond", bus.cond_o, 0);
    chk("rst_b", bus.b_o, 0);
    chk("rst_ir", bus.ir_o, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("empty_in_ready", bus.in_ready, 1);

    // ADD overflow
    op(1, 3'd0, 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h11, 0, 0);
    tick();
    result("add_ovf", 32'h8000_0000, 0, 1, 0);
    chk("add_b", bus.b_o, 32'h1);
    chk("add_ir", bus.ir_o, 32'h11);

    // SUB to zero, accepted back-to-back out of FULL
    op(1, 3'd1, 32'h5, 32'h5, 0, 0, 32'h22, 0, 0);
    #1;
    chk("full_in_ready", bus.in_ready, 1);
    tick();
    result("sub_zero", 32'h0, 1, 0, 0);

    // Branch target
    op(1, 3'd0, 32'h0, 32'h55, 32'h10, 32'h100, 32'hDEAD, 1, 0);
    tick();
    result("branch", 32'h140, 0, 0, 1);
    chk("branch_b", bus.b_o, 32'h55);
    chk("branch_ir", bus.ir_o, 32'hDEAD);

    // XOR with immediate
    op(1, 3'd4, 32'h0000_F0F0, 32'h1234, 32'h0FF0, 0, 0, 0, 1);
    tick();
    result("xor_imm", 32'hFF00, 0, 0, 0);
    chk("xor_imm_b", bus.b_o, 32'h1234);

    op(1, 3'd5, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    tick();
    result("slt_true", 32'h1, 0, 0, 0);

    op(1, 3'd5, 32'h1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    tick();
    result("slt_false", 32'h0, 1, 0, 0);

    op(1, 3'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 0, 0, 0, 0);
    tick();
    result("and", 32'h0F00_0F00, 0, 0, 0);

    op(1, 3'd3, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 0, 0, 0, 0);
    tick();
    result("or", 32'hFF0F_FF0F, 0, 0, 0);

    op(1, 3'd1, 32'h8000_0000, 32'h1, 0, 0, 0, 0, 0);
    tick();
    result("sub_ovf", 32'h7FFF_FFFF, 0, 1, 0);

    op(1, 3'd7, 32'h1234, 32'h5678, 0, 0, 0, 0, 0);
    tick();
    result("reserved", 32'h0, 1, 0, 0);

    idle();
    tick();
    chk("drain_ov", bus.out_valid, 0);

    // MUL latency; in_valid during BUSY must be ignored
    op(1, 3'd6, 32'hFFFF_FFFF, 32'h2, 0, 0, 32'h66, 0, 0);
    tick();
    op(1, 3'd0, 32'h1, 32'h1, 0, 0, 0, 0, 0);
    #1;
    for (int i = 1; i < 4; i++) begin
      chk("mul_busy_ov", bus.out_valid, 0);
      chk("mul_busy_in_ready", bus.in_ready, 0);
      if (i == 3) idle();
      tick();
    end
    result("mul", 32'hFFFF_FFFE, 0, 0, 0);
    chk("mul_ir", bus.ir_o, 32'h66);
    tick();
    chk("mul_drain_ov", bus.out_valid, 0);

    // Back-pressure then back-to-back accept
    bus.out_ready = 1'b0;
    op(1, 3'd0, 32'h3, 32'h4, 0, 0, 32'h77, 0, 0);
    tick();
    op(1, 3'd0, 32'hA, 32'h14, 0, 0, 32'h88, 0, 0);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ov", bus.out_valid, 1);
      chk("bp_alu", bus.alu_o, 32'h7);
      chk("bp_ir", bus.ir_o, 32'h77);
      chk("bp_in_ready", bus.in_ready, 0);
      if (i < 3) tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", bus.in_ready, 1);
    tick();
    result("bp_next", 32'h1E, 0, 0, 0);
    chk("bp_next_ir", bus.ir_o, 32'h88);
    idle();
    tick();
    chk("bp_drain_ov", bus.out_valid, 0);

    // Flush in the second BUSY cycle, with a competing in_valid
    op(1, 3'd6, 32'h3, 32'h5, 0, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    bus.flush = 1'b1;
    op(1, 3'd0, 32'h1, 32'h1, 0, 0, 0, 0, 0);
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    tick();
    bus.flush = 1'b0;
    idle();
    #1;
    chk("flush_ov", bus.out_valid, 0);
    chk("flush_empty_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_after_ov", bus.out_valid, 0);
    end
    op(1, 3'd6, 32'h3, 32'h5, 0, 0, 0, 0, 0);
    tick();
    idle();
    chk("flush_next_ov", bus.out_valid, 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("flush_next_ov", bus.out_valid, (i == 4) ? 1 : 0);
    end
    chk("flush_next_alu", bus.alu_o, 32'hF);
    tick();

    // Reset while FULL
    bus.out_ready = 1'b0;
    op(1, 3'd0, 32'h1, 32'h2, 0, 0, 32'h99, 0, 0);
    tick();
    idle();
    result("pre_rst", 32'h3, 0, 0, 0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_full_in_ready", bus.in_ready, 0);
    tick();
    chk("rst_full_ov", bus.out_valid, 0);
    chk("rst_full_alu", bus.alu_o, 0);
    chk("rst_full_b", bus.b_o, 0);
    chk("rst_full_ir", bus.ir_o, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", bus.in_ready, 1);

    // Reset mid-MUL abandons it
    op(1, 3'd6, 32'h7, 32'h7, 0, 0, 0, 0, 0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_mul_ov", bus.out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
